// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/coin-chute/status bundle between the vending state logic and the change dispenser.
interface change_dispenser_if #(
    parameter int kNumCoins  = 3,
    parameter int kTotalBits = 31
);
    logic                  start_i;
    logic [kTotalBits-1:0] return_amount_i;
    logic                  coin_ready_i;
    logic [kNumCoins-1:0]  return_coin_o;
    logic                  busy_o;
    logic                  done_o;
    logic [kTotalBits-1:0] remainder_o;
    logic [7:0]            coin_count_o;

    modport slave (
        input  start_i, return_amount_i, coin_ready_i,
        output return_coin_o, busy_o, done_o, remainder_o, coin_count_o
    );

    modport master (
        output start_i, return_amount_i, coin_ready_i,
        input  return_coin_o, busy_o, done_o, remainder_o, coin_count_o
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays a returned balance as coins, largest first, one coin per ready cycle.
module change_dispenser #(
    parameter int kNumCoins   = 3,
    parameter int kTotalBits  = 31,
    parameter int COIN0_VALUE = 100,
    parameter int COIN1_VALUE = 500,
    parameter int COIN2_VALUE = 1000
) (
    input logic              clk,
    input logic              reset,
    change_dispenser_if.slave bus
);
    localparam int IdxW = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;
    localparam logic [kTotalBits-1:0] COIN_VALUE [3] = '{
        kTotalBits'(COIN0_VALUE), kTotalBits'(COIN1_VALUE), kTotalBits'(COIN2_VALUE)
    };

    if (kNumCoins != 3 || COIN0_VALUE <= 0 || COIN1_VALUE <= COIN0_VALUE ||
        COIN2_VALUE <= COIN1_VALUE) begin : g_bad_params
        $error("change_dispenser: need 3 coins with positive, strictly ascending values");
    end

    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    state_t                state_q, state_d;
    logic [kTotalBits-1:0] remaining_q, remaining_d;
    logic [kNumCoins-1:0]  coin_q, coin_d;
    logic [kTotalBits-1:0] remainder_q, remainder_d;
    logic [7:0]            count_q, count_d;
    logic                  found;
    logic [IdxW-1:0]       pick;

    // Values ascend, so the last coin that fits is the largest one.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (COIN_VALUE[i] <= remaining_q) begin
                found = 1'b1;
                pick  = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = '0;
        remainder_d = remainder_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    remaining_d = bus.return_amount_i;
                    count_d     = '0;
                    remainder_d = '0;
                    state_d     = DISPENSE;
                end
            end
            DISPENSE: begin
                if (bus.coin_ready_i && found) begin
                    coin_d      = kNumCoins'(1) << pick;
                    remaining_d = remaining_q - COIN_VALUE[pick];
                    count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end else if (bus.coin_ready_i) begin
                    remainder_d = remaining_q;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            remainder_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            remainder_q <= remainder_d;
            count_q     <= count_d;
        end
    end

    assign bus.return_coin_o = coin_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.done_o        = (state_q == DONE);
    assign bus.remainder_o   = remainder_q;
    assign bus.coin_count_o  = count_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized transactions checked against a division-based greedy change model.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int VAL [3] = '{100, 500, 1000};

    change_dispenser_if #(.kNumCoins(3), .kTotalBits(31)) bus ();
    change_dispenser dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int amt, input bit rnd_ready, input bit noise);
        int q[$];
        int rem;
        int issued;
        bit fin;
        bit r;
        rem = amt;
        for (int k = 2; k >= 0; k--) begin
            repeat (rem / VAL[k]) q.push_back(1 << k);
            rem = rem % VAL[k];
        end
        bus.start_i         = 1'b1;
        bus.return_amount_i = 31'(amt);
        bus.coin_ready_i    = 1'b1;
        step();
        chk("enter_busy", 32'(bus.busy_o), 1);
        chk("enter_count", 32'(bus.coin_count_o), 0);
        chk("enter_remainder", 32'(bus.remainder_o), 0);
        bus.start_i = 1'b0;
        issued = 0;
        fin = 1'b0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.coin_ready_i = r;
            if (noise) begin
                bus.start_i         = 1'($urandom_range(0, 1));
                bus.return_amount_i = 31'd500;
            end
            step();
            if (!r) begin
                chk("stall_coin", 32'(bus.return_coin_o), 0);
                chk("stall_done", 32'(bus.done_o), 0);
            end else if (q.size() > 0) begin
                issued++;
                chk("coin", 32'(bus.return_coin_o), q.pop_front());
                chk("count", 32'(bus.coin_count_o), issued > 255 ? 255 : issued);
            end else begin
                fin = 1'b1;
                chk("done", 32'(bus.done_o), 1);
                chk("done_busy", 32'(bus.busy_o), 1);
                chk("done_coin", 32'(bus.return_coin_o), 0);
                chk("remainder", 32'(bus.remainder_o), rem);
                chk("final_count", 32'(bus.coin_count_o), issued > 255 ? 255 : issued);
            end
        end
        bus.start_i         = 1'b1;
        bus.return_amount_i = 31'd500;
        step();
        chk("idle_busy", 32'(bus.busy_o), 0);
        chk("idle_done", 32'(bus.done_o), 0);
        chk("idle_coin", 32'(bus.return_coin_o), 0);
        chk("idle_remainder", 32'(bus.remainder_o), rem);
        chk("idle_count", 32'(bus.coin_count_o), issued > 255 ? 255 : issued);
        bus.start_i      = 1'b0;
        bus.coin_ready_i = 1'b0;
    endtask

    initial begin
        bus.start_i         = 1'b0;
        bus.return_amount_i = '0;
        bus.coin_ready_i    = 1'b0;
        #2;
        chk("rst_coin", 32'(bus.return_coin_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_remainder", 32'(bus.remainder_o), 0);
        chk("rst_count", 32'(bus.coin_count_o), 0);
        step();
        reset = 1'b0;
        step();
        txn(1600, 1'b0, 1'b0);
        txn(150, 1'b0, 1'b0);
        txn(2000, 1'b1, 1'b0);
        txn(0, 1'b0, 1'b0);
        txn(1600, 1'b1, 1'b1);
        txn(99, 1'b0, 1'b0);
        txn(300050, 1'b0, 1'b0);
        repeat (10) txn(int'($urandom_range(0, 6000)), 1'b1, 1'b1);
        bus.start_i         = 1'b1;
        bus.return_amount_i = 31'd1600;
        bus.coin_ready_i    = 1'b1;
        step();
        bus.start_i = 1'b0;
        step();
        chk("pre_reset_coin", 32'(bus.return_coin_o), 4);
        chk("pre_reset_count", 32'(bus.coin_count_o), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_coin", 32'(bus.return_coin_o), 0);
        chk("mid_rst_busy", 32'(bus.busy_o), 0);
        chk("mid_rst_count", 32'(bus.coin_count_o), 0);
        chk("mid_rst_remainder", 32'(bus.remainder_o), 0);
        repeat (3) begin
            step();
            chk("mid_rst_no_done", 32'(bus.done_o), 0);
        end
        reset = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus.busy_o), 0);
        txn(1600, 1'b0, 1'b0);
        txn(850, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
